// File: rtl/i2c_reg_target.sv
`timescale 1ns/1ps
// i2c_reg_target
//   I2C target holding a bank of 8-bit registers that the CPU's bit-banged
//   master reads and writes. SCL/SDA are sampled on clk_clk; SDA is driven
//   open-drain through sda_oe. Transfers: [addr+W][ptr][data...] writes at
//   the pointer with auto-increment; [addr+R][data...] reads from it.
//
//   Ports
//     clk_clk      system clock, at least 16x the SCL rate
//     reset_reset  asynchronous active-high reset
//     scl_i/sda_i  raw pad levels (asynchronous)
//     sda_oe       1 = pull SDA low, 0 = release
//     regs_flat    register bank, register k at bits [8k+7:8k]
//     wr_strobe    one-cycle pulse per data byte written
//     wr_index     register written while wr_strobe=1
//     busy         high from an address-matched START until STOP
//
//   Build option: define I2C_GLITCH_FILTER_EN to add a 3-tap majority filter
//   behind each synchronizer (suppresses 1-cycle pulses, +2 cycles latency).
module i2c_reg_target #(
    parameter logic [6:0]            DEV_ADDR = 7'h18,
    parameter int                    NUM_REGS = 16,
    parameter logic [8*NUM_REGS-1:0] REG_INIT = {NUM_REGS{8'h00}}
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_oe,
    output logic [8*NUM_REGS-1:0]       regs_flat,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic                        busy
);
    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
    } state_t;

    // ---------------- input conditioning ----------------
    logic [1:0] scl_sync, sda_sync;
    logic       scl, sda, scl_d, sda_d;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_taps, sda_taps;
    logic       scl_filt, sda_filt;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // A level must be present in two of three consecutive samples to pass.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            scl_taps <= 2'b11;
            sda_taps <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_taps <= {scl_taps[0], scl_sync[1]};
            sda_taps <= {sda_taps[0], sda_sync[1]};
            scl_filt <= maj3(scl_sync[1], scl_taps[0], scl_taps[1]);
            sda_filt <= maj3(sda_sync[1], sda_taps[0], sda_taps[1]);
        end
    end

    assign scl = scl_filt;
    assign sda = sda_filt;
`else
    assign scl = scl_sync[1];
    assign sda = sda_sync[1];
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl;
            sda_d <= sda;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl & ~scl_d;
    assign scl_fall  = ~scl &  scl_d;
    assign start_det =  scl &  scl_d &  sda_d & ~sda;
    assign stop_det  =  scl &  scl_d & ~sda_d &  sda;

    // ---------------- register bank ----------------
    logic [7:0]    regs [NUM_REGS];
    logic [7:0]    wr_data;
    logic [PW-1:0] ptr;
    logic [7:0]    rd_byte;

    // NOTE: the bank is reset like any other state because REG_INIT defines
    // its power-up contents; it is small enough to live in flops.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= REG_INIT[8*k +: 8];
        end else if (wr_strobe) begin
            regs[wr_index] <= wr_data;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) regs_flat[8*k +: 8] = regs[k];
    end

    assign rd_byte = regs[ptr];

    // ---------------- protocol FSM ----------------
    state_t        state, state_next;
    logic [7:0]    shift, shift_next;
    logic [3:0]    cnt, cnt_next;
    logic [PW-1:0] ptr_next, wr_index_next;
    logic [7:0]    wr_data_next;
    logic          rw, rw_next, ack_ok, ack_ok_next;
    logic          oe_next, busy_next, wr_strobe_next;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state     <= S_IDLE;
            shift     <= 8'h00;
            cnt       <= 4'd0;
            ptr       <= '0;
            rw        <= 1'b0;
            ack_ok    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            wr_data   <= 8'h00;
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            cnt       <= cnt_next;
            ptr       <= ptr_next;
            rw        <= rw_next;
            ack_ok    <= ack_ok_next;
            sda_oe    <= oe_next;
            busy      <= busy_next;
            wr_strobe <= wr_strobe_next;
            wr_index  <= wr_index_next;
            wr_data   <= wr_data_next;
        end
    end

    // Bytes complete on the SCL fall after the 8th rise, so every sda_oe
    // change lands in the cycle after a detected falling edge.
    always_comb begin
        // NOTE: every output gets a default first; a path that skips an
        // assignment would otherwise infer a latch.
        state_next     = state;
        shift_next     = shift;
        cnt_next       = cnt;
        ptr_next       = ptr;
        rw_next        = rw;
        ack_ok_next    = ack_ok;
        oe_next        = sda_oe;
        busy_next      = busy;
        wr_strobe_next = 1'b0;
        wr_index_next  = wr_index;
        wr_data_next   = wr_data;

        if (stop_det) begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
            oe_next    = 1'b0;
            cnt_next   = 4'd0;
        end else if (start_det) begin
            state_next = S_ADDR;
            oe_next    = 1'b0;
            cnt_next   = 4'd0;
        end else begin
            case (state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shift_next = {shift[6:0], sda};
                        cnt_next   = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        cnt_next = 4'd0;
                        case (state)
                            S_ADDR: begin
                                if (shift[7:1] == DEV_ADDR) begin
                                    state_next = S_ADDR_ACK;
                                    oe_next    = 1'b1;
                                    busy_next  = 1'b1;
                                    rw_next    = shift[0];
                                end else begin
                                    state_next = S_IDLE;
                                end
                            end
                            S_PTR: begin
                                ptr_next   = shift[PW-1:0];
                                state_next = S_PTR_ACK;
                                oe_next    = 1'b1;
                            end
                            default: begin
                                wr_strobe_next = 1'b1;
                                wr_index_next  = ptr;
                                wr_data_next   = shift;
                                ptr_next       = ptr + 1'b1;
                                state_next     = S_WDATA_ACK;
                                oe_next        = 1'b1;
                            end
                        endcase
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_next = 4'd0;
                        if (rw) begin
                            state_next = S_RDATA;
                            shift_next = rd_byte;
                            oe_next    = ~rd_byte[7];
                        end else begin
                            state_next = S_PTR;
                            oe_next    = 1'b0;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_next = S_WDATA;
                        oe_next    = 1'b0;
                        cnt_next   = 4'd0;
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        cnt_next = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            state_next = S_RACK;
                            oe_next    = 1'b0;
                            ptr_next   = ptr + 1'b1;
                            cnt_next   = 4'd0;
                        end else begin
                            shift_next = {shift[6:0], 1'b0};
                            oe_next    = ~shift[6];
                        end
                    end
                end
                S_RACK: begin
                    // Master's ACK is sampled on the rise; acted on at the fall.
                    if (scl_rise) begin
                        ack_ok_next = ~sda;
                    end else if (scl_fall) begin
                        if (ack_ok) begin
                            state_next = S_RDATA;
                            shift_next = rd_byte;
                            oe_next    = ~rd_byte[7];
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_reg_target.sv
`timescale 1ns/1ps
// tb_i2c_reg_target
//   Bit-banged I2C master driving i2c_reg_target. Expected register writes and
//   read bytes are queued when stimulus is issued; monitor processes pop and
//   compare when the DUT pulses wr_strobe or the master finishes a read byte.
module tb_i2c_reg_target;
    localparam int           NUM_REGS = 16;
    localparam int           Q        = 8;   // clk cycles per quarter SCL period
    localparam logic [127:0] INIT     = 128'hEFEE_EDEC_EBEA_E9E8_E7E6_E5E4_E3E2_E1E0;

`ifdef I2C_GLITCH_FILTER_EN
    localparam logic [7:0] GLITCH_EXP = 8'h5A;
`else
    // The false edge re-samples the MSB, so the byte closes one bit early.
    localparam logic [7:0] GLITCH_EXP = 8'h2D;
`endif

    typedef struct {
        int         idx;
        logic [7:0] data;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         scl_m = 1'b1;
    logic         sda_m = 1'b1;
    logic         sda_bus, sda_oe, wr_strobe, busy;
    logic [127:0] regs_flat;
    logic [3:0]   wr_index;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_reg_target #(
        .DEV_ADDR (7'h18),
        .NUM_REGS (NUM_REGS),
        .REG_INIT (INIT)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .scl_i       (scl_m),
        .sda_i       (sda_bus),
        .sda_oe      (sda_oe),
        .regs_flat   (regs_flat),
        .wr_strobe   (wr_strobe),
        .wr_index    (wr_index),
        .busy        (busy)
    );

    int         checks = 0;
    int         errors = 0;
    int         oe_cycles = 0;
    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] mdl [NUM_REGS];
    logic [7:0] rd_obs;
    event       rd_ev;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mdl_flat();
        logic [127:0] f;
        for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = mdl[k];
        return f;
    endfunction

    task automatic check_bank(input string name);
        checks++;
        if (regs_flat !== mdl_flat()) begin
            errors++;
            $display("FAIL %s: regs=%h expected=%h", name, regs_flat, mdl_flat());
        end
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < NUM_REGS; k++) mdl[k] = INIT[8*k +: 8];
    endtask

    task automatic push_wr(input int idx, input logic [7:0] data);
        wr_t e;
        e.idx  = idx;
        e.data = data;
        exp_wr.push_back(e);
        mdl[idx] = data;
    endtask

    // ---------------- monitors ----------------
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (sda_oe) oe_cycles++;
            if (wr_strobe) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: write to index %0d, none expected", wr_index);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_index", int'(wr_index), e.idx);
                    @(negedge clk);
                    check("wr_data", int'(regs_flat[8*e.idx +: 8]), int'(e.data));
                end
            end
        end
    end

    initial begin
        forever begin
            @(rd_ev);
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: read 0x%0h, none expected", rd_obs);
            end else begin
                check("rd_byte", int'(rd_obs), int'(exp_rd.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bus master ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    // Sends the n most significant bits of b; glitch selects a bit position
    // (0 = MSB) that gets a one-cycle low pulse on SCL while SCL is high.
    task automatic write_bits(input logic [7:0] b, input int n, input int glitch);
        for (int i = 0; i < n; i++) begin
            sda_m = b[7-i]; wait_clk(Q);
            scl_m = 1'b1;
            if (i == glitch) begin
                wait_clk(Q);
                scl_m = 1'b0; wait_clk(1);
                scl_m = 1'b1; wait_clk(Q - 1);
            end else begin
                wait_clk(2*Q);
            end
            scl_m = 1'b0; wait_clk(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch, output logic ack);
        write_bits(b, 8, glitch);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        ack = sda_bus; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] b;
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q);
            scl_m = 1'b1; wait_clk(Q);
            b[i] = sda_bus; wait_clk(Q);
            scl_m = 1'b0; wait_clk(Q);
        end
        rd_obs = b;
        -> rd_ev;
        sda_m = nack; wait_clk(Q);
        scl_m = 1'b1; wait_clk(2*Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic ack;
        int   oe_snap;

        mdl_reset();
        wait_clk(3);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_strobe", int'(wr_strobe), 0);
        check("rst_wr_index", int'(wr_index), 0);
        check_bank("rst_regs");
        rst = 1'b0;
        wait_clk(4);

        // Write [0x30, 0x05, 0xA1, 0x7F]
        push_wr(5, 8'hA1);
        push_wr(6, 8'h7F);
        i2c_start();
        write_byte(8'h30, -1, ack); check("t1_ack_addr", int'(ack), 0);
        check("t1_busy", int'(busy), 1);
        write_byte(8'h05, -1, ack); check("t1_ack_ptr", int'(ack), 0);
        write_byte(8'hA1, -1, ack); check("t1_ack_d0", int'(ack), 0);
        write_byte(8'h7F, -1, ack); check("t1_ack_d1", int'(ack), 0);
        i2c_stop();
        check("t1_busy_clear", int'(busy), 0);
        check_bank("t1_regs");

        // Preload 3..5, then pointer 3, repeated START, read 3 bytes
        push_wr(3, 8'h11);
        push_wr(4, 8'h22);
        push_wr(5, 8'h33);
        i2c_start();
        write_byte(8'h30, -1, ack); check("t2_ack_addr_w", int'(ack), 0);
        write_byte(8'h03, -1, ack); check("t2_ack_ptr", int'(ack), 0);
        write_byte(8'h11, -1, ack);
        write_byte(8'h22, -1, ack);
        write_byte(8'h33, -1, ack); check("t2_ack_last", int'(ack), 0);
        i2c_stop();
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33);
        i2c_start();
        write_byte(8'h30, -1, ack);
        write_byte(8'h03, -1, ack);
        i2c_start();
        write_byte(8'h31, -1, ack); check("t2_ack_addr_r", int'(ack), 0);
        read_byte(1'b0);
        read_byte(1'b0);
        read_byte(1'b1);
        check("t2_release", int'(sda_oe), 0);
        check("t2_busy_nack", int'(busy), 1);
        i2c_stop();
        check("t2_busy_stop", int'(busy), 0);

        // Wrong address and general call stay silent
        oe_snap = oe_cycles;
        i2c_start();
        write_byte(8'h32, -1, ack); check("t3_nack_addr", int'(ack), 1);
        check("t3_busy", int'(busy), 0);
        write_byte(8'h01, -1, ack);
        write_byte(8'h55, -1, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'h00, -1, ack); check("t3_nack_gencall", int'(ack), 1);
        i2c_stop();
        check("t3_silent", oe_cycles - oe_snap, 0);
        check_bank("t3_regs");

        // Pointer wrap
        push_wr(15, 8'hAA);
        push_wr(0, 8'hBB);
        i2c_start();
        write_byte(8'h30, -1, ack);
        write_byte(8'h0F, -1, ack);
        write_byte(8'hAA, -1, ack);
        write_byte(8'hBB, -1, ack); check("t4_ack_wrap", int'(ack), 0);
        i2c_stop();
        check_bank("t4_regs");

        // STOP after 4 data bits: no write, pointer still 2
        i2c_start();
        write_byte(8'h30, -1, ack);
        write_byte(8'h02, -1, ack);
        write_bits(8'hFF, 4, -1);
        i2c_stop();
        check_bank("t5_regs");
        exp_rd.push_back(8'hE2);
        i2c_start();
        write_byte(8'h31, -1, ack); check("t5_ack_addr_r", int'(ack), 0);
        read_byte(1'b1);
        i2c_stop();

        // Reset in the middle of a read of register 3 (0x11, MSB 0 -> driven)
        i2c_start();
        write_byte(8'h31, -1, ack);
        wait_clk(Q);
        check("t6_driving", int'(sda_oe), 1);
        rst = 1'b1;
        #1;
        check("t6_async_release", int'(sda_oe), 0);
        mdl_reset();
        check_bank("t6_regs_init");
        check("t6_busy", int'(busy), 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);

        // One-cycle SCL glitch during the MSB of a data byte
        push_wr(8, GLITCH_EXP);
        i2c_start();
        write_byte(8'h30, -1, ack);
        write_byte(8'h08, -1, ack);
        write_byte(8'h5A, 0, ack);
        i2c_stop();
        check_bank("t7_regs");

        wait_clk(4 * Q);
        check("wr_drained", exp_wr.size(), 0);
        check("rd_drained", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
- I2C target (responder): the other end of the bit-banged I2C master on the Nios II SCL/SDA PIO exports.
- Holds an 8-bit register bank that the CPU reads and writes over I2C. The bank holds AGC gain, threshold and attack/release settings, and stands in for the codec in system simulation.
- Samples SCL/SDA on the system clock and drives SDA open-drain.

Parameters:
- DEV_ADDR, 7'h18, 7-bit target address this block responds to.
- NUM_REGS, 16, number of 8-bit registers; power of two, 2..256.
- REG_INIT, {NUM_REGS{8'h00}}, flat reset contents; register k is bits [8k+7:8k].

Ports:
- clk_clk  input  1  system clock; must be at least 16x the SCL frequency.
- reset_reset  input  1  asynchronous, active-high reset.
- scl_i  input  1  SCL pad level (asynchronous).
- sda_i  input  1  SDA pad level (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- regs_flat  output  8*NUM_REGS  current register bank contents.
- wr_strobe  output  1  one-cycle pulse per data byte written.
- wr_index  output  $clog2(NUM_REGS)  register written when wr_strobe=1.
- busy  output  1  high from an address-matched START until STOP.

Behaviour:
- Reset values:
  - sda_oe=0, wr_strobe=0, wr_index=0, busy=0.
  - regs_flat=REG_INIT, state=IDLE, pointer=0.
- Input conditioning:
  - 2-flop synchronizer on scl_i and sda_i, reset to 1.
  - Edge and START/STOP detection use the synchronized values and their 1-cycle-delayed copies.
- Bus event detection:
  - START: SDA falls while SCL=1. STOP: SDA rises while SCL=1. Both are recognised in any state.
  - START (including repeated START) -> state ADDR, bit count cleared, sda_oe released the next cycle.
  - STOP -> IDLE, busy=0, sda_oe=0.
- Sampling and driving:
  - Data bits are sampled on the detected SCL rising edge, MSB first.
  - The target changes sda_oe only on the cycle after a detected SCL falling edge. SDA never changes while SCL is high.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift in 8 bits.
    - addr[7:1]==DEV_ADDR -> ADDR_ACK, busy=1, latch R/W.
    - Otherwise -> IDLE and stay silent until the next START.
  - ADDR_ACK: drive sda_oe=1 for one SCL clock.
    - W -> PTR. R -> RDATA, loading the shift register with the register at the pointer.
  - PTR: shift in 8 bits. Pointer = byte mod NUM_REGS. Then -> PTR_ACK (ACK) -> WDATA.
  - WDATA: shift in 8 bits, then write the register at the pointer.
    - wr_strobe pulses 1 cycle with wr_index = pointer (pre-increment value).
    - Pointer increments and wraps NUM_REGS-1 -> 0.
    - -> WDATA_ACK (ACK) -> WDATA.
  - RDATA: drive the inverted shift-register MSB onto sda_oe for each bit, 8 bits.
    - Pointer increments (wraps) after the 8th bit.
    - -> RACK, with SDA released.
  - RACK: sample the master's ACK on the SCL rise.
    - ACK (0) -> reload the shift register from the new pointer -> RDATA.
    - NACK (1) -> IDLE with SDA released; stays busy until STOP.
- Boundary conditions:
  - Repeated START after PTR (write-pointer then read) keeps the pointer.
  - A START or STOP mid-byte aborts the byte: no register write, no pointer change.
  - A write to register k is visible on regs_flat the cycle after wr_strobe.
  - Reset mid-transfer releases SDA immediately (asynchronous) and restores REG_INIT.
  - General call (address 0) is not acknowledged.

Optional Feature:
- I2C_GLITCH_FILTER_EN
- Defined:
  - Adds a 3-tap majority filter after each synchronizer. Pulses of 1 clk_clk or less are suppressed.
  - Adds 2 cycles of input latency. The sda_oe update-after-falling-edge rule is unchanged relative to the filtered SCL.
- Undefined: synchronizer only; a 1-cycle glitch can create a false edge.

Test Plan:
- Write [0x30, 0x05, 0xA1, 0x7F]:
  - Required: ACK on all four bytes. Registers 5=0xA1 and 6=0x7F.
  - Required: wr_strobe pulses with wr_index 5 then 6. STOP clears busy.
- Write ptr 0x03, repeated START, read [0x31] with 3 bytes ACK,ACK,NACK:
  - Preload registers 3..5 = 0x11,0x22,0x33.
  - Required: SDA returns 0x11, 0x22, 0x33; block releases on NACK.
- Address 0x19 write:
  - Required: sda_oe stays 0 for the whole transfer, busy=0, no register change.
- Pointer wrap with NUM_REGS=16: ptr 0x0F, write 0xAA,0xBB.
  - Required: register 15=0xAA and register 0=0xBB.
- Abort and reset:
  - STOP after 4 bits of a data byte -> no write, pointer unchanged.
  - reset_reset asserted mid-read -> sda_oe=0 the same cycle, regs_flat=REG_INIT.
- With I2C_GLITCH_FILTER_EN: 1-cycle low glitch on SCL during WDATA.
  - Required: bit count unchanged and the byte is written correctly.
  - Without the macro, the same glitch corrupts the byte.
